// File: rtl/logic_reduce_pkg.sv
// Shared definitions for the logic reduction pipeline: op-code type and values.
package logic_reduce_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'b000;
  localparam op_t OP_OR   = 3'b001;
  localparam op_t OP_XOR  = 3'b010;
  localparam op_t OP_NAND = 3'b011;
  localparam op_t OP_NOR  = 3'b100;
  localparam op_t OP_XNOR = 3'b101;
  localparam op_t OP_PASS = 3'b110;
  localparam op_t OP_ZERO = 3'b111;

endpackage

// File: rtl/logic_reduce_core.sv
// Purely combinational bitwise reduction of NUM_IN operands of WIDTH bits.
// Inverting ops invert the full N-input reduction, never a pairwise chain.
module logic_reduce_core
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  op_t                     in_op,
  output logic [WIDTH-1:0]        result
);

  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;

  // Fold every operand into the three base reductions, then pick by op.
  always_comb begin
    // NOTE: blocking assignments here are intentional; each loop iteration
    // must see the accumulated value from the previous one.
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      and_r = and_r & in_data[i*WIDTH +: WIDTH];
      or_r  = or_r  | in_data[i*WIDTH +: WIDTH];
      xor_r = xor_r ^ in_data[i*WIDTH +: WIDTH];
    end
    case (in_op)
      OP_AND:  result = and_r;
      OP_OR:   result = or_r;
      OP_XOR:  result = xor_r;
      OP_NAND: result = ~and_r;
      OP_NOR:  result = ~or_r;
      OP_XNOR: result = ~xor_r;
      OP_PASS: result = in_data[WIDTH-1:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_reduce_pipe.sv
// Logic reduction with a combinational tap and a 2-entry in-order result
// buffer behind a valid/ready handshake, plus a saturating accept counter.
module logic_reduce_pipe
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  op_t                     in_op,
  output logic [WIDTH-1:0]        out_comb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic                    out_ones,
  output logic [CNT_W-1:0]        txn_count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             ones;
  } entry_t;

  logic [WIDTH-1:0] red;
  logic             push;
  logic             pop;

  entry_t           mem_q [2];
  entry_t           mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] txn_q, txn_d;

  logic_reduce_core #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_core (
    .in_data (in_data),
    .in_op   (in_op),
    .result  (red)
  );

  assign out_comb  = red;

  // Handshake flags depend only on registered occupancy.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry is gated so an empty buffer always presents zeros.
  assign out_data  = out_valid ? mem_q[rd_ptr_q].data : '0;
  assign out_zero  = out_valid & mem_q[rd_ptr_q].zero;
  assign out_ones  = out_valid & mem_q[rd_ptr_q].ones;
  assign txn_count = txn_q;

  // Next-state for pointers, occupancy, storage and the accept counter.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    txn_d    = txn_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{data: red, zero: (red == '0), ones: (red == '1)};
      wr_ptr_d        = ~wr_ptr_q;
      if (txn_q != '1) begin
        txn_d = txn_q + CNT_W'(1);
      end
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      txn_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      txn_q    <= txn_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; an emptied buffer hides stale
    // contents because the outputs are gated by out_valid.
    mem_q <= mem_d;
  end

endmodule

// File: doc/logic_reduce_pipe.md
LOGIC_REDUCE_PIPE -- requirements
Module: logic_reduce_pipe

Interface
REQ-001 Parameter WIDTH, default 8, is the bit width of each operand and result (legal range 1..32).
REQ-002 Parameter NUM_IN, default 2, is the number of operands reduced per transaction (legal range 2..8).
REQ-003 Parameter CNT_W, default 16, is the width of the accepted-transaction counter.
REQ-004 clk  input  1  the block's one clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  producer holds a valid operand set and op.
REQ-007 in_ready  output  1  block can accept a transaction this cycle.
REQ-008 in_data  input  NUM_IN*WIDTH  operands, operand i at bits [i*WIDTH +: WIDTH].
REQ-009 in_op  input  3  operation select, encoded per REQ-015.
REQ-010 out_comb  output  WIDTH  unregistered result of in_data/in_op, valid every cycle regardless of handshake.
REQ-011 out_valid  output  1  out_data/out_zero/out_ones hold a valid result.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 out_data, out_zero, out_ones  output  WIDTH, 1, 1  registered result; zero flag (all bits 0); ones flag (all bits 1).
REQ-014 txn_count  output  CNT_W  number of accepted input transactions, saturating.

Function
REQ-015 in_op SHALL select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR (each a bitwise reduction across all NUM_IN operands), 110 pass operand 0, 111 all-zero.
REQ-016 NAND/NOR/XNOR SHALL be the bitwise inverse of the full NUM_IN-input AND/OR/XOR, not a chained pairwise inversion.
REQ-017 out_comb SHALL equal the REQ-015 result of current in_data/in_op with zero cycles latency.
REQ-018 An input transfer SHALL occur on an edge where in_valid and in_ready are both 1; the result is computed from in_data/in_op sampled at that edge.
REQ-019 Results SHALL be held in a 2-entry in-order output buffer; in_ready SHALL be 1 when fewer than 2 entries are held, derived from registered state only (no combinational in_valid/out_ready to in_ready path).
REQ-020 An output transfer SHALL occur on an edge where out_valid and out_ready are both 1; out_valid SHALL be 1 iff the buffer holds at least one entry; out_data shows the oldest entry.
REQ-021 Latency: a transfer accepted into an empty buffer at edge k SHALL present out_valid=1 with its result in the cycle after edge k.
REQ-022 Simultaneous input and output transfer on one edge SHALL leave occupancy unchanged; with out_ready held 1 throughput SHALL be one result per cycle.
REQ-023 When full (2 entries), in_ready=0 and no input is accepted even if out_ready=1 that cycle; in_ready returns to 1 the cycle after an output transfer.
REQ-024 out_data/out_zero/out_ones SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 out_zero/out_ones SHALL be computed at acceptance and stored with the entry; when WIDTH=1, exactly one of them is 1 per valid entry.
REQ-026 txn_count SHALL increment by 1 per input transfer and stick at 2^CNT_W-1 without wrapping.

Reset
REQ-027 While rst_n=0 at an edge: buffer emptied, out_valid=0, out_data=0, out_zero=0, out_ones=0, txn_count=0; in_ready=1 from the first cycle after reset.
REQ-028 Reset asserted mid-operation SHALL discard all held entries with no output transfer; in-flight handshakes at that edge are ignored.
REQ-029 out_comb SHALL be unaffected by reset.

Structure
REQ-030 Op codes (OP_AND..OP_ZERO) and the 3-bit op type SHALL live in shared package logic_reduce_pkg.
REQ-031 The combinational reduction SHALL be sub-module logic_reduce_core (params WIDTH, NUM_IN), instantiated once; its output drives both out_comb and the buffer write data.

Verification
REQ-032 WIDTH=8,NUM_IN=2: in_data={8'hF0,8'h3C}, op=AND, out_ready=1 -> out_comb=8'h30 same cycle, out_data=8'h30 with out_valid one cycle after acceptance, flags 0/0.
REQ-033 NUM_IN=3: operands 8'hFF,8'h0F,8'hF0, op=XNOR -> out_data=8'hFF, out_ones=1; op=XOR -> 8'h00, out_zero=1.
REQ-034 out_ready=0, three back-to-back valid inputs -> first two accepted, in_ready=0 on the third; raise out_ready -> results emerge in order, third accepted the cycle after the first output transfer.
REQ-035 Continuous in_valid/out_ready=1 for 20 cycles -> 20 results, one per cycle, txn_count=20.
REQ-036 CNT_W=4, 20 accepted transfers -> txn_count stops at 15.
REQ-037 Buffer holding 2 entries, rst_n=0 for one edge -> out_valid=0, txn_count=0, in_ready=1 next cycle, no stale result emitted.
